// File: rtl/sc_mux41_scan_ctrl.sv
// Round-robin select generator for a 4:1 active-low-select mux with channel mask,
// forced/held select and change strobe. Define SC_MUXSCAN_DIR_EN to add descending scan.
module sc_mux41_scan_ctrl #(
  parameter int PRESCALE_WIDTH = 16,
  parameter int PRESCALE_MAX   = 49999
) (
  input  logic       SC_MUXSCAN_CLOCK_50,
  input  logic       SC_MUXSCAN_RESET_InLow,
`ifdef SC_MUXSCAN_DIR_EN
  input  logic       SC_MUXSCAN_dirDown_InHigh,
`endif
  input  logic       SC_MUXSCAN_run_InHigh,
  input  logic [3:0] SC_MUXSCAN_mask_InHigh,
  input  logic       SC_MUXSCAN_forceLoad_InHigh,
  input  logic [1:0] SC_MUXSCAN_forceSel_In,
  output logic [1:0] SC_MUXSCAN_select_Out,
  output logic       SC_MUXSCAN_valid_OutHigh,
  output logic       SC_MUXSCAN_strobe_OutHigh,
  output logic       SC_MUXSCAN_allMasked_OutHigh
);

  typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_HOLD} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                sel_q, sel_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic                      strobe_q, strobe_d;
  logic                      all_masked_q;
  logic                      dir_down;
  logic                      mask_any;
  logic                      valid_d;

`ifdef SC_MUXSCAN_DIR_EN
  assign dir_down = SC_MUXSCAN_dirDown_InHigh;
`else
  assign dir_down = 1'b0;
`endif

  assign mask_any = |SC_MUXSCAN_mask_InHigh;

  // Entry channel: lowest enabled when ascending, highest when descending.
  function automatic logic [1:0] first_chan(input logic [3:0] m, input logic down);
    logic [1:0] res;
    res = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (down && m[i])                res = 2'(i);
      if (!down && m[3 - i])           res = 2'(3 - i);
    end
    return res;
  endfunction

  // Nearest enabled channel after cur in scan order; cur itself if none other.
  function automatic logic [1:0] next_chan(input logic [1:0] cur, input logic [3:0] m,
                                           input logic down);
    logic [1:0] res;
    logic [1:0] cand;
    res = cur;
    for (int i = 3; i >= 1; i--) begin
      cand = down ? (cur - 2'(i)) : (cur + 2'(i));
      if (m[cand]) res = cand;
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (SC_MUXSCAN_forceLoad_InHigh) begin
      state_d = ST_HOLD;
      sel_d   = SC_MUXSCAN_forceSel_In;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (SC_MUXSCAN_run_InHigh && mask_any) begin
            state_d = ST_DWELL;
            sel_d   = first_chan(SC_MUXSCAN_mask_InHigh, dir_down);
            cnt_d   = '0;
          end
        end
        ST_DWELL: begin
          if (!SC_MUXSCAN_run_InHigh || !mask_any) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (!SC_MUXSCAN_mask_InHigh[sel_q] ||
                       (cnt_q == PRESCALE_WIDTH'(PRESCALE_MAX))) begin
            sel_d = next_chan(sel_q, SC_MUXSCAN_mask_InHigh, dir_down);
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + PRESCALE_WIDTH'(1);
          end
        end
        ST_HOLD: begin
          // Keep the forced select on release; the masked-channel rule fixes it up next cycle.
          state_d = (SC_MUXSCAN_run_InHigh && mask_any) ? ST_DWELL : ST_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    valid_d  = (state_d != ST_IDLE);
    strobe_d = (sel_d != sel_q) || (valid_d && (state_q == ST_IDLE));
  end

  always_ff @(posedge SC_MUXSCAN_CLOCK_50 or negedge SC_MUXSCAN_RESET_InLow) begin
    if (!SC_MUXSCAN_RESET_InLow) begin
      state_q      <= ST_IDLE;
      sel_q        <= 2'b00;
      cnt_q        <= '0;
      strobe_q     <= 1'b0;
      all_masked_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      strobe_q     <= strobe_d;
      all_masked_q <= !mask_any;
    end
  end

  assign SC_MUXSCAN_select_Out        = sel_q;
  assign SC_MUXSCAN_valid_OutHigh     = (state_q != ST_IDLE);
  assign SC_MUXSCAN_strobe_OutHigh    = strobe_q;
  assign SC_MUXSCAN_allMasked_OutHigh = all_masked_q;

endmodule

// File: tb/tb_sc_mux41_scan_ctrl.sv
// Scoreboard bench for sc_mux41_scan_ctrl (PRESCALE_MAX = 3); a cycle model pushes the
// expected outputs per stimulus cycle and the monitor pops them after the clock edge.
module tb_sc_mux41_scan_ctrl;
  localparam int PMAX = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] mask = 4'h0;
  logic       fl = 1'b0;
  logic [1:0] fs = 2'b00;
  logic       dn = 1'b0;
  logic [1:0] sel_o;
  logic       valid_o, strobe_o, am_o;

  sc_mux41_scan_ctrl #(.PRESCALE_WIDTH(4), .PRESCALE_MAX(PMAX)) dut (
    .SC_MUXSCAN_CLOCK_50         (clk),
    .SC_MUXSCAN_RESET_InLow      (rst_n),
`ifdef SC_MUXSCAN_DIR_EN
    .SC_MUXSCAN_dirDown_InHigh   (dn),
`endif
    .SC_MUXSCAN_run_InHigh       (run),
    .SC_MUXSCAN_mask_InHigh      (mask),
    .SC_MUXSCAN_forceLoad_InHigh (fl),
    .SC_MUXSCAN_forceSel_In      (fs),
    .SC_MUXSCAN_select_Out       (sel_o),
    .SC_MUXSCAN_valid_OutHigh    (valid_o),
    .SC_MUXSCAN_strobe_OutHigh   (strobe_o),
    .SC_MUXSCAN_allMasked_OutHigh(am_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic       valid;
    logic       strobe;
    logic       am;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: 0 idle, 1 dwell, 2 hold
  int         m_st;
  logic [1:0] m_sel;
  int         m_cnt;
  logic       m_valid;

  logic [1:0] obs_sel;
  logic       obs_valid, obs_strobe, obs_am;
  int         strobe_cnt;
  logic [1:0] strobe_sels[$];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] m_adv(input logic [1:0] cur, input logic [3:0] m,
                                       input logic down);
    logic [1:0] c;
    c = cur;
    for (int k = 0; k < 3; k++) begin
      c = down ? c - 2'd1 : c + 2'd1;
      if (m[c]) return c;
    end
    return cur;
  endfunction

  function automatic logic [1:0] m_first(input logic [3:0] m, input logic down);
    if (down) begin
      for (int k = 3; k >= 0; k--) if (m[k]) return 2'(k);
    end else begin
      for (int k = 0; k < 4; k++) if (m[k]) return 2'(k);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_sel = 2'b00; m_cnt = 0; m_valid = 1'b0;
  endtask

  // Called at a negedge: drive inputs, predict, clock, then compare one transaction.
  task automatic step(input logic r, input logic [3:0] m, input logic f,
                      input logic [1:0] fsel, input logic d);
    logic [1:0] old_sel;
    logic       old_valid, eff_dn;
    exp_t       e, got_e;
    run = r; mask = m; fl = f; fs = fsel; dn = d;
`ifdef SC_MUXSCAN_DIR_EN
    eff_dn = d;
`else
    eff_dn = 1'b0;
`endif
    old_sel = m_sel; old_valid = m_valid;
    if (f) begin
      m_st = 2; m_sel = fsel; m_cnt = 0;
    end else if (m_st == 0) begin
      if (r && m != 4'h0) begin m_st = 1; m_sel = m_first(m, eff_dn); m_cnt = 0; end
    end else if (m_st == 1) begin
      if (!r || m == 4'h0) begin m_st = 0; m_cnt = 0; end
      else if (!m[m_sel] || m_cnt == PMAX) begin m_sel = m_adv(m_sel, m, eff_dn); m_cnt = 0; end
      else m_cnt++;
    end else begin
      m_st = (r && m != 4'h0) ? 1 : 0; m_cnt = 0;
    end
    m_valid = (m_st != 0);
    e.sel = m_sel; e.valid = m_valid; e.am = (m == 4'h0);
    e.strobe = (m_sel != old_sel) || (m_valid && !old_valid);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    obs_sel = sel_o; obs_valid = valid_o; obs_strobe = strobe_o; obs_am = am_o;
    chk_val("sb_sel", 32'(obs_sel), 32'(got_e.sel));
    chk_val("sb_valid", 32'(obs_valid), 32'(got_e.valid));
    chk_val("sb_strobe", 32'(obs_strobe), 32'(got_e.strobe));
    chk_val("sb_allmasked", 32'(obs_am), 32'(got_e.am));
    if (obs_strobe) begin strobe_cnt++; strobe_sels.push_back(obs_sel); end
    $display("t=%0t run=%b mask=%b fl=%b fs=%0d dn=%b -> sel=%0d v=%b stb=%b am=%b",
             $time, r, m, f, fsel, d, obs_sel, obs_valid, obs_strobe, obs_am);
    @(negedge clk);
  endtask

  task automatic step_until_sel(input string tag, input logic [1:0] target,
                                input logic r, input logic [3:0] m, input logic d);
    for (int i = 0; i < 40 && obs_sel != target; i++) step(r, m, 1'b0, 2'b00, d);
    chk_val(tag, 32'(obs_sel), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] exp_seq[5];
    model_reset();
    obs_sel = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk_val("rst_sel", 32'(sel_o), 32'd0);
    chk_val("rst_valid", 32'(valid_o), 32'd0);
    chk_val("rst_strobe", 32'(strobe_o), 32'd0);
    chk_val("rst_allmasked", 32'(am_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: reset mid-dwell on channel 2, then full ascending scan
    step_until_sel("t1_reach_sel2", 2'd2, 1'b1, 4'hF, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("t1_async_sel", 32'(sel_o), 32'd0);
    chk_val("t1_async_valid", 32'(valid_o), 32'd0);
    chk_val("t1_async_strobe", 32'(strobe_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    strobe_cnt = 0; strobe_sels.delete();
    for (int i = 0; i < 17; i++) step(1'b1, 4'hF, 1'b0, 2'b00, 1'b0);
    chk_val("t1_strobe_count", 32'(strobe_cnt), 32'd5);
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5 && i < strobe_sels.size(); i++)
      chk_val("t1_seq", 32'(strobe_sels[i]), 32'(exp_seq[i]));

    // 2: sparse mask, then single channel
    strobe_cnt = 0; strobe_sels.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 4'b1010, 1'b0, 2'b00, 1'b0);
    chk_val("t2_strobe_count", 32'(strobe_cnt), 32'd4);
    exp_seq = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd0};
    for (int i = 0; i < 4 && i < strobe_sels.size(); i++)
      chk_val("t2_seq", 32'(strobe_sels[i]), 32'(exp_seq[i]));
    strobe_cnt = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 4'b1000, 1'b0, 2'b00, 1'b0);
    chk_val("t2_single_sel", 32'(obs_sel), 32'd3);
    chk_val("t2_single_nostrobe", 32'(strobe_cnt), 32'd0);

    // 3: current channel masked mid-dwell
    step_until_sel("t3_reach_sel2", 2'd2, 1'b1, 4'hF, 1'b0);
    step(1'b1, 4'hF, 1'b0, 2'b00, 1'b0);
    step(1'b1, 4'b1011, 1'b0, 2'b00, 1'b0);
    chk_val("t3_skip_sel", 32'(obs_sel), 32'd3);
    chk_val("t3_skip_strobe", 32'(obs_strobe), 32'd1);
    strobe_cnt = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1011, 1'b0, 2'b00, 1'b0);
    chk_val("t3_restart_nostrobe", 32'(strobe_cnt), 32'd0);
    step(1'b1, 4'b1011, 1'b0, 2'b00, 1'b0);
    chk_val("t3_restart_adv", 32'(obs_sel), 32'd0);

    // 4: forced hold, mask ignored, release into dwell
    step_until_sel("t4_reach_sel1", 2'd1, 1'b1, 4'hF, 1'b0);
    step(1'b1, 4'hF, 1'b1, 2'd2, 1'b0);
    chk_val("t4_force_sel", 32'(obs_sel), 32'd2);
    chk_val("t4_force_strobe", 32'(obs_strobe), 32'd1);
    strobe_cnt = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 4'h0, 1'b1, 2'd2, 1'b0);
    chk_val("t4_hold_sel", 32'(obs_sel), 32'd2);
    chk_val("t4_hold_valid", 32'(obs_valid), 32'd1);
    chk_val("t4_hold_nostrobe", 32'(strobe_cnt), 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'hF, 1'b0, 2'd2, 1'b0);
      n++;
      if (obs_strobe) break;
    end
    chk_val("t4_release_dwell", 32'(n), 32'd5);
    chk_val("t4_release_next", 32'(obs_sel), 32'd3);
    step(1'b1, 4'hF, 1'b1, 2'd0, 1'b0);
    step(1'b1, 4'hF, 1'b1, 2'd1, 1'b0);
    step(1'b1, 4'b1101, 1'b0, 2'd1, 1'b0);
    step(1'b1, 4'b1101, 1'b0, 2'd1, 1'b0);
    chk_val("t4_masked_release", 32'(obs_sel), 32'd2);

    // 5: run drop, all masked, restart
    step_until_sel("t5_reach_sel3", 2'd3, 1'b1, 4'hF, 1'b0);
    step(1'b0, 4'hF, 1'b0, 2'd0, 1'b0);
    chk_val("t5_idle_valid", 32'(obs_valid), 32'd0);
    chk_val("t5_idle_sel", 32'(obs_sel), 32'd3);
    chk_val("t5_idle_strobe", 32'(obs_strobe), 32'd0);
    step(1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
    chk_val("t5_allmasked", 32'(obs_am), 32'd1);
    step(1'b1, 4'b0100, 1'b0, 2'd0, 1'b0);
    chk_val("t5_restart_sel", 32'(obs_sel), 32'd2);
    chk_val("t5_restart_valid", 32'(obs_valid), 32'd1);
    chk_val("t5_restart_strobe", 32'(obs_strobe), 32'd1);
    step(1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 2'd1, 1'b0);
    chk_val("t5_force_from_idle", 32'(obs_strobe), 32'd1);
    step(1'b0, 4'h0, 1'b0, 2'd1, 1'b0);

`ifdef SC_MUXSCAN_DIR_EN
    // 6: descending scan, direction toggle does not restart the dwell
    strobe_cnt = 0; strobe_sels.delete();
    for (int i = 0; i < 17; i++) step(1'b1, 4'hF, 1'b0, 2'd0, 1'b1);
    exp_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    chk_val("t6_strobe_count", 32'(strobe_cnt), 32'd5);
    for (int i = 0; i < 5 && i < strobe_sels.size(); i++)
      chk_val("t6_seq", 32'(strobe_sels[i]), 32'(exp_seq[i]));
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'hF, 1'b0, 2'd0, (i % 2) == 0);
      n++;
      if (obs_strobe) break;
    end
    chk_val("t6_toggle_dwell", 32'(n), 32'd4);
`endif

    chk_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sc_mux41_scan_ctrl.md
Name: sc_mux41_scan_ctrl

Overview:
- Sequential select generator sitting directly upstream of the 4:1 active-low-select multiplexer (CC_MUX41AL).
- Steps the 2-bit select round-robin across the four mux inputs, dwelling a programmable number of clocks on each.
- Skips inputs disabled by a mask, supports a forced/held select, and emits a one-cycle strobe on every select change so downstream logic can resample.

Parameters:
- PRESCALE_WIDTH, 16: width of the dwell counter.
- PRESCALE_MAX, 49999: dwell length; the select advances after PRESCALE_MAX+1 clocks in DWELL. Must fit in PRESCALE_WIDTH bits.

Ports:
- SC_MUXSCAN_CLOCK_50  in  1  system clock; all state on the rising edge.
- SC_MUXSCAN_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_MUXSCAN_run_InHigh  in  1  1 = scanning enabled.
- SC_MUXSCAN_mask_InHigh  in  4  bit i = 1 enables mux input i (select value i).
- SC_MUXSCAN_forceLoad_InHigh  in  1  force select to forceSel and hold it.
- SC_MUXSCAN_forceSel_In  in  2  forced select value.
- SC_MUXSCAN_select_Out  out  2  drives CC_MUX41AL_select_InLow.
- SC_MUXSCAN_valid_OutHigh  out  1  1 = select is meaningful (DWELL or HOLD).
- SC_MUXSCAN_strobe_OutHigh  out  1  one-cycle pulse on the cycle select_Out takes a new value.
- SC_MUXSCAN_allMasked_OutHigh  out  1  registered; 1 when mask == 4'b0000.

Behaviour:
- Reset (async, on RESET_InLow = 0):
  - select_Out = 2'b00, valid = 0, strobe = 0, allMasked = 0.
  - Dwell counter = 0, state = IDLE.
  - Release is sampled synchronously; no output change until the first edge after release.
- States: IDLE, DWELL, HOLD.
- Priority each cycle, highest first: forceLoad > (run = 0 or mask = 0) > current channel masked > dwell expiry.
- IDLE:
  - valid = 0; select_Out holds its last value.
  - If forceLoad: go to HOLD.
  - Else if run = 1 and mask != 0: select_Out = lowest-index enabled channel, counter = 0, go to DWELL.
- DWELL:
  - valid = 1; counter increments each clock.
  - When counter == PRESCALE_MAX: select_Out = next enabled channel in ascending order after the current one, wrapping 3 -> 0, and counter = 0.
  - If only the current channel is enabled, select_Out is unchanged and no strobe is issued.
  - If mask[select_Out] drops to 0 during dwell: advance to the next enabled channel on the next clock, counter = 0.
  - If run = 0 or mask = 0: go to IDLE on the next clock, valid = 0, select held.
- HOLD:
  - Entered from any state when forceLoad = 1.
  - select_Out = forceSel, valid = 1, counter held at 0, mask ignored.
  - forceSel changing while in HOLD updates select_Out next cycle.
  - On forceLoad deasserting:
    - If run = 1 and mask != 0: go to DWELL with counter = 0, keeping the current select even if that channel is masked. The masked rule then advances it one cycle later.
    - Otherwise go to IDLE.
- Latency: every select change is registered and visible 1 clock after the triggering condition.
- strobe: registered; equals 1 in exactly the cycle where select_Out differs from its previous-cycle value, or where valid rises. Never asserted in IDLE.
- allMasked: registered copy of (mask == 0), independent of state.
- Next-channel search is purely combinational over 4 bits; the counter compare is an exact equality, never an overflow.

Optional Feature:
- Macro: SC_MUXSCAN_DIR_EN.
- When defined:
  - Adds input SC_MUXSCAN_dirDown_InHigh (1 bit).
  - When dirDown = 1, advance searches in descending order (wrap 0 -> 3).
  - On entry from IDLE, selects the highest-index enabled channel.
  - Direction is sampled at each advance; a change mid-dwell does not reset the counter.
- When undefined: the port is absent and the scan is always ascending.

Test Plan (bench uses PRESCALE_MAX = 3):
1. Reset asserted mid-DWELL with select = 2'b10 -> select_Out = 00, valid = 0, strobe = 0 asynchronously. After release with run = 1, mask = 1111: select 00 with strobe, then 01, 10, 11, 00, each held 4 clocks, one strobe per change.
2. mask = 1010, run = 1 -> sequence 01, 11, 01, 11 at 4-clock intervals. Then mask = 1000 -> select stays 11, no strobe after the next expiry.
3. mask[2] cleared while dwelling on channel 2 (mask 1111 -> 1011) -> next clock select = 11, strobe = 1, counter restarts at 0.
4. forceLoad = 1, forceSel = 10 during DWELL on 01 -> next clock select = 10, strobe = 1, held for 20 clocks regardless of mask = 0000. Release with mask = 1111 -> 4-clock dwell on 10, then 11.
5. run = 0 while on 11 -> next clock valid = 0, select stays 11, no strobe. Setting mask = 0000 -> allMasked = 1 one clock later. Restoring mask = 0100 with run = 1 -> select 10, valid = 1, strobe = 1.
6. (SC_MUXSCAN_DIR_EN defined) mask = 1111, dirDown = 1 -> sequence 11, 10, 01, 00, 11. Toggling dirDown mid-dwell does not shorten the 4-clock dwell.
